// File: rtl/sat_search_driver.sv
// sat_search_driver: walks every candidate assignment of a combinational SAT circuit, pausing on each hit (ports: clk/rst, start/resume/sat in, cand/model/hits/busy/found/done/unsat out)
module sat_search_driver #(
    parameter int NUM_INPUTS = 7,
    parameter int CNT_WIDTH  = NUM_INPUTS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  resume,
    input  logic                  sat,
    output logic [NUM_INPUTS-1:0] cand,
    output logic [NUM_INPUTS-1:0] model,
    output logic [CNT_WIDTH-1:0]  hits,
    output logic                  busy,
    output logic                  found,
    output logic                  done,
    output logic                  unsat
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    localparam logic [NUM_INPUTS-1:0] LAST = '1;
    state_t                state_q, state_d;
    logic [NUM_INPUTS-1:0] cand_q, cand_d, model_q, model_d;
    logic [CNT_WIDTH-1:0]  hits_q, hits_d;
    logic                  busy_q, found_q, done_q, unsat_q;
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        model_d = model_q;
        hits_d  = hits_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RUN;
                cand_d  = '0;
                hits_d  = '0;
            end
            RUN: if (sat) begin
                state_d = HOLD;
                model_d = cand_q;
                hits_d  = hits_q + CNT_WIDTH'(1);
            end else if (cand_q == LAST) begin
                state_d = DONE;
            end else begin
                cand_d = cand_q + NUM_INPUTS'(1);
            end
            HOLD: if (resume) begin
                state_d = (cand_q == LAST) ? DONE : RUN;
                cand_d  = (cand_q == LAST) ? cand_q : cand_q + NUM_INPUTS'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    // Status flags are registered from the next state so sat never reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            model_q <= '0;
            hits_q  <= '0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
            unsat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            model_q <= model_d;
            hits_q  <= hits_d;
            busy_q  <= (state_d == RUN) || (state_d == HOLD);
            found_q <= state_d == HOLD;
            done_q  <= state_d == DONE;
            unsat_q <= (state_d == DONE) && (hits_d == '0);
        end
    end
    assign cand  = cand_q;
    assign model = model_q;
    assign hits  = hits_q;
    assign busy  = busy_q;
    assign found = found_q;
    assign done  = done_q;
    assign unsat = unsat_q;
endmodule

// File: tb/tb_sat_search_driver.sv
// tb_sat_search_driver: randomized check of sat_search_driver against a list-of-solutions reference model
module tb_sat_search_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic         start7 = 1'b0, resume7 = 1'b0, start3 = 1'b0, resume3 = 1'b0;
    logic [127:0] tbl7 = '0;
    logic [7:0]   tbl3 = 8'hFF;
    logic [6:0]   cand7, model7;
    logic [7:0]   hits7;
    logic         busy7, found7, done7, unsat7, sat7;
    logic [2:0]   cand3, model3;
    logic [3:0]   hits3;
    logic         busy3, found3, done3, unsat3, sat3;
    int           errs = 0, checks = 0;
    int           exp_model = 0;
    assign sat7 = tbl7[cand7];
    assign sat3 = tbl3[cand3];
    sat_search_driver #(.NUM_INPUTS(7)) u7 (
        .clk(clk), .rst(rst), .start(start7), .resume(resume7), .sat(sat7),
        .cand(cand7), .model(model7), .hits(hits7),
        .busy(busy7), .found(found7), .done(done7), .unsat(unsat7)
    );
    sat_search_driver #(.NUM_INPUTS(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .resume(resume3), .sat(sat3),
        .cand(cand3), .model(model3), .hits(hits3),
        .busy(busy3), .found(found3), .done(done3), .unsat(unsat3)
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic search7();
        int q[$];
        int exp_cand = 0, hit_idx = 0, runs = 0, cyc = 0;
        for (int c = 0; c < 128; c++) if (tbl7[c]) q.push_back(c);
        start7 = 1'b1;
        @(negedge clk);
        start7 = 1'b0;
        while (!done7 && cyc < 2000) begin
            cyc++;
            if (found7) begin
                check("hold_cand", 32'(cand7), exp_cand);
                check("hold_model", 32'(model7), exp_cand);
                check("hold_hits", 32'(hits7), hit_idx + 1);
                check("hold_runs", runs, exp_cand + 1);
                check("hold_busy", 32'(busy7), 1);
                exp_model = exp_cand;
                resume7 = 1'($urandom % 2);
                start7  = 1'($urandom % 2);
                if (resume7) begin
                    exp_cand++;
                    hit_idx++;
                end
            end else begin
                check("run_cand", 32'(cand7), exp_cand);
                check("run_hits", 32'(hits7), hit_idx);
                check("run_busy", 32'(busy7), 1);
                runs++;
                resume7 = 1'($urandom % 2);
                start7  = 1'($urandom % 2);
                if (!tbl7[7'(exp_cand)]) exp_cand++;
            end
            @(negedge clk);
        end
        start7  = 1'b0;
        resume7 = 1'b0;
        check("done_reached", 32'(done7), 1);
        check("done_runs", runs, 128);
        check("done_hits", 32'(hits7), q.size());
        check("done_unsat", 32'(unsat7), 32'(q.size() == 0));
        check("done_cand", 32'(cand7), 127);
        check("done_model", 32'(model7), exp_model);
        check("done_flags", {busy7, found7}, 0);
        @(negedge clk);
        check("done_stays", {done7, busy7}, 2'b10);
    endtask
    task automatic reset_mid();
        int n = 0;
        tbl7 = '0;
        start7 = 1'b1;
        @(negedge clk);
        start7 = 1'b0;
        while (cand7 != 7'h2A && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", 32'(cand7), 32'h2A);
        #2 rst = 1'b1;
        #1 check("rst_async", {cand7, model7, hits7, busy7, found7, done7, unsat7}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_model = 0;
        repeat (5) @(negedge clk);
        check("rst_idle", {cand7, hits7, busy7, done7}, 0);
    endtask
    task automatic search3();
        start3 = 1'b1;
        @(negedge clk);
        resume3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int n = 0;
            while (!found3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t1_found", 32'(found3), 1);
            check("t1_cand", 32'(cand3), k);
            check("t1_model", 32'(model3), k);
            check("t1_hits", 32'(hits3), k + 1);
            if (k == 7) start3 = 1'b0;
            @(negedge clk);
        end
        resume3 = 1'b0;
        check("t1_done", {done3, busy3, found3}, 3'b100);
        check("t1_unsat", 32'(unsat3), 0);
        check("t1_final", {cand3, hits3}, {3'd7, 4'd8});
    endtask
    initial begin
        #12;
        check("reset_state", {cand7, model7, hits7, busy7, found7, done7, unsat7}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_wait", {cand7, busy7, done7}, 0);
        tbl7 = '0;
        search7();
        reset_mid();
        for (int c = 0; c < 128; c++) tbl7[c] = (c % 16) * (c / 16) == 25;
        search7();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 128; c++) tbl7[c] = ($urandom % 8) == 0;
            search7();
        end
        tbl7 = '1;
        search7();
        search3();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
